// File: rtl/ysyx_22041412_trap_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_trap_ctrl_if
//   Bundle between the core commit stage / CLINT and the machine-mode trap
//   controller.
//   master : core side. It drives the commit information, the CSR write/read
//            addresses and the CLINT timer level. It receives read data,
//            the redirect and the pending flag.
//   slave  : trap controller side.
// Signals:
//   timer_irq      level timer interrupt from the CLINT
//   inst_valid     one instruction retires this cycle
//   inst_pc        PC of the retiring instruction
//   next_pc        architectural next PC of the retiring instruction
//   ecall / mret   retiring instruction is ecall / mret
//   csr_we, csr_waddr, csr_wdata   CSR write port
//   csr_raddr, csr_rdata           CSR read port (combinational data)
//   redirect_valid one-cycle pulse: fetch must jump and flush
//   redirect_pc    redirect target
//   irq_pending    registered copy of the timer level (mip.MTIP)
// ----------------------------------------------------------------------------
interface ysyx_22041412_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            timer_irq;
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] next_pc;
  logic            ecall;
  logic            mret;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            irq_pending;

  modport master (
    output timer_irq, inst_valid, inst_pc, next_pc, ecall, mret,
           csr_we, csr_waddr, csr_wdata, csr_raddr,
    input  csr_rdata, redirect_valid, redirect_pc, irq_pending
  );

  modport slave (
    input  timer_irq, inst_valid, inst_pc, next_pc, ecall, mret,
           csr_we, csr_waddr, csr_wdata, csr_raddr,
    output csr_rdata, redirect_valid, redirect_pc, irq_pending
  );
endinterface

// File: rtl/ysyx_22041412_trap_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_trap_ctrl
//   Machine-mode trap controller that sits after the CLINT. At each commit
//   boundary it decides between an ecall exception, a timer interrupt or an
//   mret. It owns mstatus.MIE/MPIE, mie.MTIE, mip.MTIP, mtvec, mepc and
//   mcause. It issues a registered one-cycle redirect to fetch.
// Ports:
//   clk  system clock. All state changes on the rising edge.
//   rst  synchronous, active-high reset.
//   bus  slave side of ysyx_22041412_trap_ctrl_if. It carries the commit
//        info, the CSR read/write port, the timer level, the redirect and
//        the pending flag.
// ----------------------------------------------------------------------------
module ysyx_22041412_trap_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22041412_trap_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, (XLEN-1)'(7)};
  // mtvec (direct mode only) and mepc are always 4-byte aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

  typedef enum logic {RUN, REDIR} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_ECALL, EV_IRQ, EV_MRET} event_e;

  state_e          state_q, state_d;
  event_e          ev;
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic            mie_mtie_q, mip_mtip_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, redirect_pc_q;
  logic            take_irq;
  logic [XLEN-1:0] rdata;

  // Uses only registered state. A timer edge becomes visible one cycle
  // after it reaches timer_irq.
  assign take_irq = mstatus_mie_q & mie_mtie_q & mip_mtip_q;

  // Next-state and event selection. Traps are considered only at a commit
  // in RUN. In REDIR the core is flushing, so inst_valid is ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    ev      = EV_NONE;
    case (state_q)
      RUN: begin
        if (bus.inst_valid) begin
          if (bus.ecall)      ev = EV_ECALL;
          else if (take_irq)  ev = EV_IRQ;
          else if (bus.mret)  ev = EV_MRET;
          if (ev != EV_NONE) state_d = REDIR;
        end
      end
      REDIR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // CSR and redirect registers. A trap or mret claims mstatus, mepc and
  // mcause for this edge, so a colliding core write to those is dropped.
  // Writes to mie and mtvec still land. The redirect uses the old mtvec.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST & ALIGN_MASK;
      mepc_q         <= '0;
      mcause_q       <= '0;
      redirect_pc_q  <= '0;
    end else begin
      mip_mtip_q <= bus.timer_irq;

      if (bus.csr_we) begin
        case (bus.csr_waddr)
          ADDR_MSTATUS: begin
            if (ev == EV_NONE) begin
              mstatus_mie_q  <= bus.csr_wdata[3];
              mstatus_mpie_q <= bus.csr_wdata[7];
            end
          end
          ADDR_MIE:    mie_mtie_q <= bus.csr_wdata[7];
          ADDR_MTVEC:  mtvec_q    <= bus.csr_wdata & ALIGN_MASK;
          ADDR_MEPC:   if (ev == EV_NONE) mepc_q   <= bus.csr_wdata & ALIGN_MASK;
          ADDR_MCAUSE: if (ev == EV_NONE) mcause_q <= bus.csr_wdata;
          default: ;
        endcase
      end

      case (ev)
        EV_ECALL: begin
          mepc_q         <= bus.inst_pc & ALIGN_MASK;
          mcause_q       <= CAUSE_ECALL;
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
          redirect_pc_q  <= mtvec_q;
        end
        EV_IRQ: begin
          // The retiring instruction completes. Resume at its successor.
          // If it was an mret, the mret target is saved, so the mret is
          // effectively replayed after the handler returns.
          mepc_q         <= bus.next_pc & ALIGN_MASK;
          mcause_q       <= CAUSE_MTI;
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
          redirect_pc_q  <= mtvec_q;
        end
        EV_MRET: begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
          redirect_pc_q  <= mepc_q;
        end
        default: ;
      endcase
    end
  end

  // Combinational read of pre-edge state. A write in this cycle does not
  // bypass to the read data.
  always_comb begin
    rdata = '0;
    case (bus.csr_raddr)
      ADDR_MSTATUS: begin
        rdata[12:11] = 2'b11;  // MPP is hard-wired to M-mode
        rdata[7]     = mstatus_mpie_q;
        rdata[3]     = mstatus_mie_q;
      end
      ADDR_MIE:    rdata[7] = mie_mtie_q;
      ADDR_MIP:    rdata[7] = mip_mtip_q;
      ADDR_MTVEC:  rdata    = mtvec_q;
      ADDR_MEPC:   rdata    = mepc_q;
      ADDR_MCAUSE: rdata    = mcause_q;
      default:     rdata    = '0;
    endcase
  end

  assign bus.csr_rdata      = rdata;
  assign bus.redirect_valid = (state_q == REDIR);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.irq_pending    = mip_mtip_q;

endmodule

// File: tb/tb_ysyx_22041412_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041412_trap_ctrl
//   Self-checking bench for the trap controller. The first part is a directed
//   walk through reset, interrupt, mret, ecall, idle-pending and collision
//   cases. The second part is a randomized run. Both parts are compared every
//   cycle against an architectural model of the trap CSRs.
// ----------------------------------------------------------------------------
module tb_ysyx_22041412_trap_ctrl;

  localparam int          XLEN      = 32;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;

  logic clk;
  logic rst;

  ysyx_22041412_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  ysyx_22041412_trap_ctrl #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural state as seen by software, plus the expected redirect.
  typedef struct {
    bit          mie;
    bit          mpie;
    bit          mtie;
    bit          mtip;
    bit          rv;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] rpc;
  } model_t;

  typedef enum {T_NONE, T_ECALL, T_IRQ, T_MRET} trap_e;

  model_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m.mpie) << 7) | (32'(m.mie) << 3);
      12'h304: return 32'(m.mtie) << 7;
      12'h344: return 32'(m.mtip) << 7;
      12'h305: return m.mtvec;
      12'h341: return m.mepc;
      12'h342: return m.mcause;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    model_t n;
    trap_e  ev;
    if (rst) begin
      n       = '{default: 0};
      n.mtvec = MTVEC_RST & ~32'h3;
    end else begin
      n      = m;
      n.mtip = bus.timer_irq;
      n.rv   = 1'b0;
      ev     = T_NONE;
      if (!m.rv && bus.inst_valid) begin
        if (bus.ecall)                      ev = T_ECALL;
        else if (m.mie && m.mtie && m.mtip) ev = T_IRQ;
        else if (bus.mret)                  ev = T_MRET;
      end
      if (bus.csr_we) begin
        case (bus.csr_waddr)
          12'h300: if (ev == T_NONE) begin
            n.mie  = bus.csr_wdata[3];
            n.mpie = bus.csr_wdata[7];
          end
          12'h304: n.mtie = bus.csr_wdata[7];
          12'h305: n.mtvec = bus.csr_wdata & ~32'h3;
          12'h341: if (ev == T_NONE) n.mepc = bus.csr_wdata & ~32'h3;
          12'h342: if (ev == T_NONE) n.mcause = bus.csr_wdata;
          default: ;
        endcase
      end
      case (ev)
        T_ECALL: begin
          n.mepc = bus.inst_pc & ~32'h3; n.mcause = 32'd11;
          n.mpie = m.mie; n.mie = 1'b0; n.rpc = m.mtvec; n.rv = 1'b1;
        end
        T_IRQ: begin
          n.mepc = bus.next_pc & ~32'h3; n.mcause = 32'h8000_0007;
          n.mpie = m.mie; n.mie = 1'b0; n.rpc = m.mtvec; n.rv = 1'b1;
        end
        T_MRET: begin
          n.mie = m.mpie; n.mpie = 1'b1; n.rpc = m.mepc; n.rv = 1'b1;
        end
        default: ;
      endcase
    end
    m = n;
  endtask

  // One clock: update the model, cross the edge, and compare outputs 1ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("redirect_valid", 32'(bus.redirect_valid), 32'(m.rv));
    check("redirect_pc", bus.redirect_pc, m.rpc);
    check("irq_pending", 32'(bus.irq_pending), 32'(m.mtip));
    check("csr_rdata", bus.csr_rdata, model_read(bus.csr_raddr));
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    bus.csr_raddr = a;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  task automatic clear();
    bus.inst_valid = 1'b0;
    bus.ecall      = 1'b0;
    bus.mret       = 1'b0;
    bus.csr_we     = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we    = 1'b1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] npc);
    bus.inst_valid = 1'b1;
    bus.inst_pc    = pc;
    bus.next_pc    = npc;
  endtask

  logic [11:0] addr_tab [7] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342, 12'h340};

  initial begin
    m = '{default: 0};
    clear();
    bus.timer_irq = 1'b0;
    bus.inst_pc   = '0;
    bus.next_pc   = '0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    bus.csr_raddr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h305, MTVEC_RST, "rst_mtvec");
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);

    // Timer interrupt taken at commit
    clear(); csr_wr(12'h305, 32'h8000_0103); tick();
    clear(); csr_wr(12'h304, 32'h0000_0080); tick();
    clear(); csr_wr(12'h300, 32'h0000_0008); tick();
    clear(); bus.timer_irq = 1'b1; tick();
    clear(); commit(32'h8000_003c, 32'h8000_0040); tick();
    check("irq_rv", 32'(bus.redirect_valid), 32'h1);
    check("irq_rpc", bus.redirect_pc, 32'h8000_0100);
    rd(12'h341, 32'h8000_0040, "irq_mepc");
    rd(12'h342, 32'h8000_0007, "irq_mcause");
    rd(12'h300, 32'h0000_1880, "irq_mstatus");
    clear(); tick();
    check("irq_pulse_end", 32'(bus.redirect_valid), 32'h0);

    // mret returns to mepc; the still-pending timer traps again at the next commit
    clear(); commit(32'h8000_0100, 32'h8000_0104); bus.mret = 1'b1; tick();
    check("mret_rv", 32'(bus.redirect_valid), 32'h1);
    check("mret_rpc", bus.redirect_pc, 32'h8000_0040);
    rd(12'h300, 32'h0000_1888, "mret_mstatus");
    clear(); tick();
    clear(); commit(32'h8000_0040, 32'h8000_0044); tick();
    check("retrap_rv", 32'(bus.redirect_valid), 32'h1);
    rd(12'h342, 32'h8000_0007, "retrap_mcause");
    rd(12'h341, 32'h8000_0044, "retrap_mepc");
    clear(); tick();

    // ecall beats a simultaneous interrupt; a single redirect
    clear(); csr_wr(12'h300, 32'h0000_0008); tick();
    clear(); commit(32'h8000_0010, 32'h8000_0014); bus.ecall = 1'b1; tick();
    check("ecall_rv", 32'(bus.redirect_valid), 32'h1);
    rd(12'h341, 32'h8000_0010, "ecall_mepc");
    rd(12'h342, 32'h0000_000b, "ecall_mcause");
    clear(); tick();
    check("ecall_single_1", 32'(bus.redirect_valid), 32'h0);
    tick();
    check("ecall_single_2", 32'(bus.redirect_valid), 32'h0);

    // Pending interrupt without commit does nothing; the first commit traps
    clear(); csr_wr(12'h300, 32'h0000_0008); tick();
    clear();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_no_redirect", 32'(bus.redirect_valid), 32'h0);
    end
    commit(32'h8000_0020, 32'h8000_0024); tick();
    check("idle_first_commit_rv", 32'(bus.redirect_valid), 32'h1);
    rd(12'h342, 32'h8000_0007, "idle_mcause");
    clear(); tick();

    // MIE=0 now: timer visible in mip, commit does not trap
    rd(12'h344, 32'h0000_0080, "mie0_mip");
    clear(); commit(32'h8000_0030, 32'h8000_0034); tick();
    check("mie0_no_trap", 32'(bus.redirect_valid), 32'h0);
    clear(); tick();

    // Write to mepc dropped when colliding with ecall; reset during REDIR
    clear(); commit(32'h0000_0200, 32'h0000_0204); bus.ecall = 1'b1;
    csr_wr(12'h341, 32'h0000_1234); tick();
    check("coll_rv", 32'(bus.redirect_valid), 32'h1);
    rd(12'h341, 32'h0000_0200, "coll_mepc");
    clear(); bus.timer_irq = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_redir_rv", 32'(bus.redirect_valid), 32'h0);
    check("rst_redir_rpc", bus.redirect_pc, 32'h0);
    rd(12'h300, 32'h0000_1800, "rst2_mstatus");
    rd(12'h341, 32'h0, "rst2_mepc");
    rd(12'h342, 32'h0, "rst2_mcause");
    clear(); tick();
    rd(12'h305, MTVEC_RST, "rst2_mtvec");
    rd(12'h304, 32'h0, "rst2_mie");
    rd(12'h344, 32'h0, "rst2_mip");

    // Interrupt + mret together, with an mtvec write in the same cycle
    clear(); csr_wr(12'h304, 32'h0000_0080); bus.timer_irq = 1'b1; tick();
    clear(); csr_wr(12'h300, 32'h0000_0008); tick();
    clear(); commit(32'h0000_0100, 32'h0000_0050); bus.mret = 1'b1;
    csr_wr(12'h305, 32'h0000_0400); tick();
    check("irqmret_rpc_old_mtvec", bus.redirect_pc, MTVEC_RST);
    rd(12'h341, 32'h0000_0050, "irqmret_mepc");
    rd(12'h305, 32'h0000_0400, "irqmret_mtvec");
    clear(); tick();

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.timer_irq  = ($urandom_range(0, 3) != 0);
      bus.inst_valid = $urandom_range(0, 1) == 1;
      bus.inst_pc    = $urandom;
      bus.next_pc    = $urandom;
      bus.ecall      = ($urandom_range(0, 7) == 0);
      bus.mret       = ($urandom_range(0, 5) == 0);
      bus.csr_we     = ($urandom_range(0, 2) == 0);
      bus.csr_waddr  = addr_tab[$urandom_range(0, 6)];
      bus.csr_wdata  = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0000_0088;
      bus.csr_raddr  = addr_tab[$urandom_range(0, 6)];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
